// File: rtl/rv32ic_fetch_aligner.sv
// RV32IC fetch aligner: turns 32-bit fetch words into whole 16/32-bit instructions with PCs.
// Optional RV32IC_ALIGN_ILLEGAL_EN adds out_illegal for the all-zero compressed encoding.
module rv32ic_fetch_aligner #(
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic [PC_WIDTH-1:0] flush_pc,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_inst,
  output logic [PC_WIDTH-1:0] out_pc,
`ifdef RV32IC_ALIGN_ILLEGAL_EN
  output logic                out_illegal,
`endif
  output logic                out_is_c
);

  // Queue occupancy doubles as the FSM state.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    PART  = 2'd1,
    FULL2 = 2'd2,
    FULL3 = 2'd3
  } state_e;

  state_e                     state_q, state_d;
  logic [2:0][15:0]           q_q, q_d, sh;
  logic [PC_WIDTH-1:0]        pc_q, pc_d;
  logic                       skip_q, skip_d;

  logic       head_c, emit, accept;
  logic [1:0] cnt, pop, push, base;
  logic [2:0] cnt_d;
  logic [1:0][15:0] ins;

  assign cnt       = state_q;
  assign head_c    = q_q[0][1:0] != 2'b11;
  assign out_valid = head_c ? (cnt >= 2'd1) : (cnt >= 2'd2);
  assign out_is_c  = (cnt != 2'd0) && head_c;
  assign out_inst  = head_c ? {16'h0000, q_q[0]} : {q_q[1], q_q[0]};
  assign out_pc    = pc_q;
  assign in_ready  = !flush && (cnt <= 2'd1);
`ifdef RV32IC_ALIGN_ILLEGAL_EN
  assign out_illegal = out_valid && out_is_c && (q_q[0] == 16'h0000);
`endif

  assign emit   = out_valid && out_ready;
  assign accept = in_valid && in_ready;
  assign pop    = emit ? (head_c ? 2'd1 : 2'd2) : 2'd0;
  assign push   = accept ? (skip_q ? 2'd1 : 2'd2) : 2'd0;
  assign base   = cnt - pop;
  // A misaligned start consumes only the high half of the first word.
  assign ins[0] = skip_q ? in_data[31:16] : in_data[15:0];
  assign ins[1] = in_data[31:16];

  always_comb begin
    sh = q_q;
    case (pop)
      2'd1:    sh = {q_q[2], q_q[2], q_q[1]};
      2'd2:    sh = {q_q[2], q_q[2], q_q[2]};
      default: sh = q_q;
    endcase
    q_d = sh;
    for (int i = 0; i < 3; i++) begin
      if (accept && 2'(i) == base)
        q_d[i] = ins[0];
      else if (accept && !skip_q && 2'(i) == base + 2'd1)
        q_d[i] = ins[1];
    end
  end

  always_comb begin
    cnt_d   = 3'({1'b0, cnt}) - 3'({1'b0, pop}) + 3'({1'b0, push});
    state_d = state_e'(cnt_d[1:0]);
    pc_d    = pc_q;
    skip_d  = skip_q;
    if (flush) begin
      state_d = EMPTY;
      pc_d    = flush_pc;
      skip_d  = flush_pc[1];
    end else begin
      if (emit)   pc_d   = pc_q + (head_c ? PC_WIDTH'(2) : PC_WIDTH'(4));
      if (accept) skip_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      q_q     <= '0;
      pc_q    <= RESET_PC;
      skip_q  <= RESET_PC[1];
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      pc_q    <= pc_d;
      skip_q  <= skip_d;
    end
  end

endmodule

// File: tb/tb_rv32ic_fetch_aligner.sv
// Bench for rv32ic_fetch_aligner: spec vectors, directed corner sequences, random vs a halfword-queue model.
module tb_rv32ic_fetch_aligner;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] flush_pc, in_data;
  logic        in_ready, out_valid, out_is_c;
  logic [31:0] out_inst, out_pc;
`ifdef RV32IC_ALIGN_ILLEGAL_EN
  logic        out_illegal;
`endif

  always #5 clk = ~clk;

  rv32ic_fetch_aligner dut (
    .clk(clk), .reset(reset), .flush(flush), .flush_pc(flush_pc),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_pc(out_pc),
`ifdef RV32IC_ALIGN_ILLEGAL_EN
    .out_illegal(out_illegal),
`endif
    .out_is_c(out_is_c)
  );

  int checks = 0;
  int errors = 0;

  // Reference: a plain queue of pending halfwords plus the PC of the head.
  logic [15:0] mq[$];
  logic [31:0] mpc;
  logic        mskip;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mpc   = 32'h0;
    mskip = 1'b0;
  endtask

  // Drive one cycle, compare DUT against the model before the edge, advance the model.
  task automatic cyc(input logic fl, input logic [31:0] fpc, input logic iv,
                     input logic [31:0] d, input logic ordy);
    int n;
    logic ev, ec, erdy;
    logic [31:0] einst;
    flush = fl; flush_pc = fpc; in_valid = iv; in_data = d; out_ready = ordy;
    #1;
    n     = mq.size();
    ec    = 1'b0;
    ev    = 1'b0;
    einst = 32'h0;
    if (n >= 1) begin
      ec = mq[0][1:0] != 2'b11;
      if (ec) begin
        ev = 1'b1;
        einst = {16'h0, mq[0]};
      end else if (n >= 2) begin
        ev = 1'b1;
        einst = {mq[1], mq[0]};
      end
    end
    erdy = !fl && n <= 1;
    chk("in_ready", {31'h0, in_ready}, {31'h0, erdy});
    chk("out_valid", {31'h0, out_valid}, {31'h0, ev});
    chk("out_pc", out_pc, mpc);
    if (ev) begin
      chk("out_inst", out_inst, einst);
      chk("out_is_c", {31'h0, out_is_c}, {31'h0, ec});
    end
`ifdef RV32IC_ALIGN_ILLEGAL_EN
    chk("out_illegal", {31'h0, out_illegal}, {31'h0, ev && ec && einst == 32'h0});
`endif
    if (fl) begin
      mq.delete();
      mpc   = fpc;
      mskip = fpc[1];
    end else begin
      if (ev && ordy) begin
        void'(mq.pop_front());
        if (!ec) void'(mq.pop_front());
        mpc = mpc + (ec ? 32'd2 : 32'd4);
      end
      if (iv && erdy) begin
        if (!mskip) mq.push_back(d[15:0]);
        mq.push_back(d[31:16]);
        mskip = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy);
    cyc(1'b0, 32'h0, 1'b0, 32'h0, ordy);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  typedef struct {
    logic [31:0] fpc;
    logic [31:0] word;
    logic [31:0] epc;
    logic [31:0] einst;
    logic        ec;
  } vec_t;

  vec_t vt[6];

  function automatic logic [15:0] rand_half();
    logic [31:0] r;
    r = $urandom;
    if (r[31:29] == 3'd0) return 16'h0000;
    return r[15:0];
  endfunction

  initial begin
    logic [31:0] w, fp, frz_inst, frz_pc;
    vt[0] = '{32'h0000_0000, 32'h4501_4581, 32'h0000_0000, 32'h0000_4581, 1'b1};
    vt[1] = '{32'h0000_0000, 32'h0000_0013, 32'h0000_0000, 32'h0000_0013, 1'b0};
    vt[2] = '{32'h0000_0102, 32'h0001_FFFF, 32'h0000_0102, 32'h0000_0001, 1'b1};
    vt[3] = '{32'h0000_0004, 32'h8082_0001, 32'h0000_0004, 32'h0000_0001, 1'b1};
    vt[4] = '{32'h0000_0106, 32'h1234_5678, 32'h0000_0106, 32'h0000_1234, 1'b1};
    vt[5] = '{32'hFFFF_FFFC, 32'h00A0_0093, 32'hFFFF_FFFC, 32'h00A0_0093, 1'b0};

    reset = 1'b1; flush = 1'b0; flush_pc = 32'h0; in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b0;
    model_reset();
    #1;
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("rst_out_inst", out_inst, 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_is_c", {31'h0, out_is_c}, 32'h0);
    do_reset();

    // Spec test 1: two compressed halves, one per cycle.
    cyc(1'b0, 32'h0, 1'b1, 32'h4501_4581, 1'b1);
    chk("t1_pc0", out_pc, 32'h0);
    chk("t1_inst0", out_inst, 32'h0000_4581);
    idle(1'b1);
    chk("t1_pc2", out_pc, 32'h2);
    chk("t1_inst2", out_inst, 32'h0000_4501);
    chk("t1_c2", {31'h0, out_is_c}, 32'h1);
    idle(1'b1);

    // Table: flush to a PC, accept one word, first instruction visible next cycle.
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, vt[i].fpc, 1'b0, 32'h0, 1'b0);
      cyc(1'b0, 32'h0, 1'b1, vt[i].word, 1'b0);
      chk($sformatf("vec%0d_valid", i), {31'h0, out_valid}, 32'h1);
      chk($sformatf("vec%0d_pc", i), out_pc, vt[i].epc);
      chk($sformatf("vec%0d_inst", i), out_inst, vt[i].einst);
      chk($sformatf("vec%0d_c", i), {31'h0, out_is_c}, {31'h0, vt[i].ec});
    end

    // Spec test 3: 32-bit instruction straddling two words.
    cyc(1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 32'h0013_4581, 1'b1);
    chk("t3_pc0", out_pc, 32'h0);
    cyc(1'b0, 32'h0, 1'b1, 32'h4501_0000, 1'b1);
    chk("t3_wait_upper", {31'h0, out_valid}, 32'h0);
    cyc(1'b0, 32'h0, 1'b1, 32'h4501_0000, 1'b1);
    chk("t3_pc2", out_pc, 32'h2);
    chk("t3_inst32", out_inst, 32'h0000_0013);
    chk("t3_c32", {31'h0, out_is_c}, 32'h0);
    idle(1'b1);
    chk("t3_pc6", out_pc, 32'h6);
    chk("t3_inst6", out_inst, 32'h0000_4501);
    idle(1'b1);

    // Spec test 5: three compressed halves queued, stall, then drain.
    cyc(1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 32'h4501_4581, 1'b0);
    idle(1'b1);
    cyc(1'b0, 32'h0, 1'b1, 32'h4509_4505, 1'b0);
    frz_inst = out_inst;
    frz_pc   = out_pc;
    chk("t5_full_pc", frz_pc, 32'h2);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0);
      chk("t5_frozen_inst", out_inst, 32'h0000_4501);
      chk("t5_frozen_pc", out_pc, 32'h2);
      chk("t5_no_ready", {31'h0, in_ready}, 32'h0);
    end
    for (int k = 0; k < 3; k++) begin
      chk("t5_drain_pc", out_pc, 32'h2 + 32'(2 * k));
      idle(1'b1);
    end
    chk("t5_empty", {31'h0, out_valid}, 32'h0);

    // Spec test 6: async reset mid-stream with two halves queued.
    cyc(1'b0, 32'h0, 1'b1, 32'h0013_4581, 1'b0);
    reset = 1'b1;
    #1;
    chk("t6_valid", {31'h0, out_valid}, 32'h0);
    chk("t6_ready", {31'h0, in_ready}, 32'h1);
    chk("t6_pc", out_pc, 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc(1'b0, 32'h0, 1'b1, 32'h0000_0000, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Random traffic with occasional redirects, some near the PC wrap.
    for (int k = 0; k < 1500; k++) begin
      w  = {rand_half(), rand_half()};
      fp = $urandom;
      fp[0] = 1'b0;
      if ($urandom_range(0, 3) == 0) fp[31:4] = 28'hFFF_FFFF;
      cyc(($urandom_range(0, 24) == 0), fp, ($urandom_range(0, 3) != 0), w,
          ($urandom_range(0, 3) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
